// File: rtl/spi_fl_responder.sv
// spi_fl_responder: single-lane mode-3 SPI flash target. Oversamples ss/sclk/mosi
// in the clk domain, decodes command/address/dummy phases and bridges read and
// program data to a byte-wide backing-memory port.
// Optional build macro: SPI_FL_RESP_ADDR4_EN adds 4-byte addressing (0xB7/0xE9).
module spi_fl_responder #(
    parameter int unsigned DUMMY_CYCLES = 8,
    parameter logic [23:0] JEDEC_ID     = 24'hC22018
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ss,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [7:0]  status,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        wr_valid,
    output logic [31:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        cmd_valid,
    output logic [7:0]  cmd
);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_IGNORE} state_t;
    typedef enum logic [1:0] {SRC_MEM, SRC_JEDEC, SRC_STAT} src_t;

    localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_CYCLES - 1);

    logic [1:0]  r_ss_s, r_sclk_s, r_mosi_s;
    logic        r_ss_d, r_sclk_d;
    logic [1:0]  r_vld;
    logic        r_armed;

    state_t      r_state;
    src_t        r_src;
    logic [4:0]  r_bcnt;
    logic [2:0]  r_tx_cnt;
    logic [7:0]  r_rx, r_txsh, r_next;
    logic [31:0] r_addr;
    logic [1:0]  r_jidx;
    logic        r_rd_req_d;
    logic        r_miso, r_oe, r_rd_req, r_wr_valid, r_cmd_valid;
    logic [31:0] r_rd_addr, r_wr_addr;
    logic [7:0]  r_wr_data, r_cmd;

    logic        w_rise, w_fall, w_ss_fall, w_ss_rise, w_mosi;
    logic        w_addr4;
    logic [31:0] w_amask, w_addr_in;
    logic [4:0]  w_alast;
    logic [7:0]  w_rx, w_jnext;

`ifdef SPI_FL_RESP_ADDR4_EN
    logic        r_addr4;
    assign w_addr4 = r_addr4;
`else
    assign w_addr4 = 1'b0;
`endif

    // Synchronizers and edge-detect history; a falling ss is only honoured once
    // ss has been seen high after reset, so a reset mid-frame stays silent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ss_s   <= 2'b11;
            r_sclk_s <= 2'b11;
            r_mosi_s <= '0;
            r_ss_d   <= 1'b1;
            r_sclk_d <= 1'b1;
            r_vld    <= '0;
            r_armed  <= 1'b0;
        end else begin
            r_ss_s   <= {r_ss_s[0], ss};
            r_sclk_s <= {r_sclk_s[0], sclk};
            r_mosi_s <= {r_mosi_s[0], mosi};
            r_ss_d   <= r_ss_s[1];
            r_sclk_d <= r_sclk_s[1];
            r_vld    <= {r_vld[0], 1'b1};
            if (r_vld[1] && r_ss_s[1]) r_armed <= 1'b1;
        end
    end

    assign w_rise    = ~r_sclk_d & r_sclk_s[1];
    assign w_fall    = r_sclk_d & ~r_sclk_s[1];
    assign w_ss_fall = r_armed & r_ss_d & ~r_ss_s[1];
    assign w_ss_rise = ~r_ss_d & r_ss_s[1];
    assign w_mosi    = r_mosi_s[1];
    assign w_amask   = w_addr4 ? 32'hFFFF_FFFF : 32'h00FF_FFFF;
    assign w_alast   = w_addr4 ? 5'd31 : 5'd23;
    assign w_rx      = {r_rx[6:0], w_mosi};
    assign w_addr_in = {r_addr[30:0], w_mosi} & w_amask;

    // Next ID byte to stage after the one currently queued; zeros once exhausted.
    always_comb begin
        w_jnext = 8'h00;
        case (r_jidx)
            2'd1:    w_jnext = JEDEC_ID[15:8];
            2'd2:    w_jnext = JEDEC_ID[7:0];
            default: w_jnext = 8'h00;
        endcase
    end

    // Frame FSM: decodes phases, drives miso on falling edges, issues strobes.
    // r_next stages the byte for the next bit-7 slot so prefetch never disturbs
    // the byte that is currently shifting out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_src       <= SRC_MEM;
            r_bcnt      <= '0;
            r_tx_cnt    <= '0;
            r_rx        <= '0;
            r_txsh      <= '0;
            r_next      <= '0;
            r_addr      <= '0;
            r_jidx      <= '0;
            r_rd_req_d  <= 1'b0;
            r_miso      <= 1'b0;
            r_oe        <= 1'b0;
            r_rd_req    <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_rd_addr   <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_cmd       <= '0;
`ifdef SPI_FL_RESP_ADDR4_EN
            r_addr4     <= 1'b0;
`endif
        end else begin
            r_rd_req    <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_rd_req_d  <= r_rd_req;
            if (r_rd_req_d) r_next <= rd_data;

            case (r_state)
                S_IDLE: begin
                    if (w_ss_fall) begin
                        r_state <= S_CMD;
                        r_bcnt  <= '0;
                    end
                end
                S_CMD: begin
                    if (w_rise) begin
                        r_rx   <= w_rx;
                        r_bcnt <= r_bcnt + 5'd1;
                        if (r_bcnt == 5'd7) begin
                            r_bcnt      <= '0;
                            r_cmd       <= w_rx;
                            r_cmd_valid <= 1'b1;
                            r_addr      <= '0;
                            r_tx_cnt    <= '0;
                            case (w_rx)
                                8'h03, 8'h0B, 8'h02: r_state <= S_ADDR;
                                8'h9F: begin
                                    r_state <= S_RDATA;
                                    r_src   <= SRC_JEDEC;
                                    r_next  <= JEDEC_ID[23:16];
                                    r_jidx  <= 2'd1;
                                    r_oe    <= 1'b1;
                                end
                                8'h05: begin
                                    r_state <= S_RDATA;
                                    r_src   <= SRC_STAT;
                                    r_next  <= status;
                                    r_oe    <= 1'b1;
                                end
`ifdef SPI_FL_RESP_ADDR4_EN
                                8'hB7: begin
                                    r_addr4 <= 1'b1;
                                    r_state <= S_IGNORE;
                                end
                                8'hE9: begin
                                    r_addr4 <= 1'b0;
                                    r_state <= S_IGNORE;
                                end
`endif
                                default: r_state <= S_IGNORE;
                            endcase
                        end
                    end
                end
                S_ADDR: begin
                    if (w_rise) begin
                        r_addr <= w_addr_in;
                        r_bcnt <= r_bcnt + 5'd1;
                        if (r_bcnt == w_alast) begin
                            r_bcnt <= '0;
                            if (r_cmd == 8'h02) begin
                                r_state <= S_WDATA;
                            end else if (r_cmd == 8'h0B && DUMMY_CYCLES != 0) begin
                                r_state <= S_DUMMY;
                            end else begin
                                r_state   <= S_RDATA;
                                r_src     <= SRC_MEM;
                                r_oe      <= 1'b1;
                                r_rd_req  <= 1'b1;
                                r_rd_addr <= w_addr_in;
                                r_addr    <= (w_addr_in + 32'd1) & w_amask;
                            end
                        end
                    end
                end
                S_DUMMY: begin
                    if (w_rise) begin
                        r_bcnt <= r_bcnt + 5'd1;
                        if (r_bcnt == DUMMY_LAST) begin
                            r_bcnt    <= '0;
                            r_state   <= S_RDATA;
                            r_src     <= SRC_MEM;
                            r_oe      <= 1'b1;
                            r_rd_req  <= 1'b1;
                            r_rd_addr <= r_addr;
                            r_addr    <= (r_addr + 32'd1) & w_amask;
                        end
                    end
                end
                S_RDATA: begin
                    if (w_fall) begin
                        r_tx_cnt <= r_tx_cnt + 3'd1;
                        if (r_tx_cnt == 3'd0) begin
                            r_miso <= r_next[7];
                            r_txsh <= {r_next[6:0], 1'b0};
                            case (r_src)
                                SRC_MEM: begin
                                    r_rd_req  <= 1'b1;
                                    r_rd_addr <= r_addr;
                                    r_addr    <= (r_addr + 32'd1) & w_amask;
                                end
                                SRC_JEDEC: begin
                                    r_next <= w_jnext;
                                    if (r_jidx != 2'd3) r_jidx <= r_jidx + 2'd1;
                                end
                                default: r_next <= status;
                            endcase
                        end else begin
                            r_miso <= r_txsh[7];
                            r_txsh <= {r_txsh[6:0], 1'b0};
                        end
                    end
                end
                S_WDATA: begin
                    if (w_rise) begin
                        r_rx   <= w_rx;
                        r_bcnt <= r_bcnt + 5'd1;
                        if (r_bcnt == 5'd7) begin
                            r_bcnt       <= '0;
                            r_wr_valid   <= 1'b1;
                            r_wr_data    <= w_rx;
                            r_wr_addr    <= r_addr;
                            r_addr[7:0]  <= r_addr[7:0] + 8'd1;
                        end
                    end
                end
                default: ;
            endcase

            // A completed frame wins over everything above, but strobes for a
            // byte finishing on the same cycle have already been scheduled.
            if (w_ss_rise) begin
                r_state  <= S_IDLE;
                r_bcnt   <= '0;
                r_tx_cnt <= '0;
                r_oe     <= 1'b0;
                r_miso   <= 1'b0;
            end
        end
    end

    assign miso      = r_miso;
    assign miso_oe   = r_oe;
    assign rd_req    = r_rd_req;
    assign rd_addr   = r_rd_addr;
    assign wr_valid  = r_wr_valid;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign cmd_valid = r_cmd_valid;
    assign cmd       = r_cmd;

endmodule

// File: tb/tb_spi_fl_responder.sv
// tb_spi_fl_responder: randomized frames against a frame-level reference model.
module tb_spi_fl_responder;

    localparam int unsigned DUMMY = 8;
    localparam int          HALF  = 5;
    localparam logic [23:0] JID   = 24'hC22018;

    logic        clk = 1'b0;
    logic        rst, ss, sclk, mosi;
    logic        miso, miso_oe;
    logic [7:0]  status;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic [7:0]  rd_data;
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;
    logic        cmd_valid;
    logic [7:0]  cmd;

    spi_fl_responder #(.DUMMY_CYCLES(DUMMY), .JEDEC_ID(JID)) dut (
        .clk(clk), .rst(rst), .ss(ss), .sclk(sclk), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .status(status),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .cmd_valid(cmd_valid), .cmd(cmd)
    );

    always #5 clk = ~clk;

    // Backing store contents: XOR fold of the address bytes (mem[n]=n below 256).
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24];
    endfunction
    assign rd_data = mem_byte(rd_addr);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] rd_log[$];
    logic [39:0] wr_log[$];
    logic [7:0]  cmd_log[$];
    bit          oe_seen;
    int          bad_miso = 0;
    bit          mode4 = 1'b0;

    // Strobe capture away from the active edge.
    always @(negedge clk) begin
        if (rd_req)    rd_log.push_back(rd_addr);
        if (wr_valid)  wr_log.push_back({wr_addr, wr_data});
        if (cmd_valid) cmd_log.push_back(cmd);
        if (miso_oe)   oe_seen = 1'b1;
        if (!miso_oe && miso) bad_miso++;
    end

    task automatic clear_logs();
        rd_log.delete();
        wr_log.delete();
        cmd_log.delete();
        oe_seen = 1'b0;
    endtask

    task automatic ss_low();
        @(negedge clk) ss = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ss_high();
        ss   = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // One mode-3 bit: drive on sclk fall, sample miso just before the rise.
    task automatic xbit(input logic b, input bit coinc, output logic r);
        sclk = 1'b0;
        mosi = b;
        repeat (HALF) @(negedge clk);
        r    = miso;
        sclk = 1'b1;
        if (coinc) ss = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic do_frame(input logic [7:0] c, input logic [31:0] addr, input int ndata,
                            input int cut, input bit coinc, input bit use_d, input logic [7:0] d0);
        int          abits, hdr, total, nbits, rem, exp_req, exp_wr;
        logic [31:0] amask, a, ea;
        logic        txb[$];
        logic        rxb[$];
        logic [7:0]  dat[$];
        logic [7:0]  d, rb, eb;
        logic [23:0] jid;
        bit          is_rd, is_wr, is_src;
        logic        r;
        abits  = mode4 ? 32 : 24;
        amask  = mode4 ? 32'hFFFF_FFFF : 32'h00FF_FFFF;
        a      = addr & amask;
        is_rd  = (c == 8'h03) || (c == 8'h0B);
        is_wr  = (c == 8'h02);
        is_src = (c == 8'h9F) || (c == 8'h05);
        hdr    = (is_rd || is_wr) ? 8 + abits + ((c == 8'h0B) ? int'(DUMMY) : 0) : 8;
        for (int i = 0; i < 8; i++) txb.push_back(c[7-i]);
        if (is_rd || is_wr)
            for (int i = 0; i < abits; i++) txb.push_back(a[abits-1-i]);
        if (c == 8'h0B)
            for (int i = 0; i < int'(DUMMY); i++) txb.push_back(1'($urandom_range(0, 1)));
        for (int k = 0; k < ndata; k++) begin
            d = use_d ? d0 + 8'(k) : 8'($urandom);
            dat.push_back(d);
            for (int i = 0; i < 8; i++) txb.push_back(d[7-i]);
        end
        total = txb.size();
        nbits = (cut > 0 && cut < total) ? cut : total;

        clear_logs();
        ss_low();
        for (int i = 0; i < nbits; i++) begin
            xbit(txb[i], coinc && (i == nbits - 1), r);
            rxb.push_back(r);
        end
        ss_high();

        check_eq("cmd_count", cmd_log.size(), (nbits >= 8) ? 1 : 0);
        if (nbits >= 8) begin
            check_eq("cmd_val", (cmd_log.size() > 0) ? cmd_log[0] : 8'hxx, c);
`ifdef SPI_FL_RESP_ADDR4_EN
            if (c == 8'hB7) mode4 = 1'b1;
            if (c == 8'hE9) mode4 = 1'b0;
`endif
        end
        rem = (nbits >= hdr) ? nbits - hdr : -1;

        exp_req = (is_rd && rem >= 0) ? 1 + (rem + 7) / 8 : 0;
        check_eq("rd_count", rd_log.size(), exp_req);
        for (int k = 0; k < exp_req && k < rd_log.size(); k++)
            check_eq("rd_addr", rd_log[k], (a + 32'(k)) & amask);

        exp_wr = (is_wr && rem >= 0) ? rem / 8 : 0;
        check_eq("wr_count", wr_log.size(), exp_wr);
        for (int k = 0; k < exp_wr && k < wr_log.size(); k++) begin
            ea = {a[31:8], a[7:0] + 8'(k)};
            check_eq("wr_evt", wr_log[k], {ea, dat[k]});
        end

        if ((is_rd || is_src) && rem > 0) begin
            for (int k = 0; k < rem / 8; k++) begin
                rb = '0;
                for (int j = 0; j < 8; j++) rb = {rb[6:0], rxb[hdr + 8*k + j]};
                if (is_rd) eb = mem_byte((a + 32'(k)) & amask);
                else if (c == 8'h05) eb = status;
                else begin
                    jid = JID >> (8 * (2 - k));
                    eb  = (k < 3) ? jid[7:0] : 8'h00;
                end
                check_eq("miso_byte", rb, eb);
            end
            check_eq("oe_high", oe_seen, 1);
        end else if (!(is_rd || is_src) || rem < 0) begin
            check_eq("oe_low", oe_seen, 0);
        end
    endtask

    initial begin
        logic [7:0]  c;
        logic [31:0] addr;
        logic        r;
        int          pick;
        rst = 1'b0; ss = 1'b1; sclk = 1'b1; mosi = 1'b0; status = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_miso", miso, 0);
        check_eq("rst_oe", miso_oe, 0);
        check_eq("rst_rd_req", rd_req, 0);
        check_eq("rst_wr_valid", wr_valid, 0);
        check_eq("rst_cmd_valid", cmd_valid, 0);
        check_eq("rst_cmd", cmd, 0);
        check_eq("rst_rd_addr", rd_addr, 0);
        check_eq("rst_wr_addr", wr_addr, 0);
        check_eq("rst_wr_data", wr_data, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        do_frame(8'h9F, 32'h0, 3, 0, 1'b0, 1'b0, 8'h00);
        do_frame(8'h0B, 32'h10, 2, 0, 1'b0, 1'b0, 8'h00);
        do_frame(8'h02, 32'h1FE, 3, 0, 1'b0, 1'b1, 8'hA1);
        do_frame(8'h03, 32'h0, 0, 20, 1'b0, 1'b0, 8'h00);
        status = 8'h5A;
        do_frame(8'h05, 32'h0, 2, 0, 1'b0, 1'b0, 8'h00);
        do_frame(8'h02, 32'h0000_30FF, 2, 0, 1'b1, 1'b0, 8'h00);
        do_frame(8'h03, 32'hFFFF_FFFF, 2, 0, 1'b0, 1'b0, 8'h00);
`ifdef SPI_FL_RESP_ADDR4_EN
        do_frame(8'hB7, 32'h0, 0, 0, 1'b0, 1'b0, 8'h00);
        do_frame(8'h03, 32'hAA5A_5A11, 1, 0, 1'b0, 1'b0, 8'h00);
        do_frame(8'h03, 32'hFFFF_FFFF, 2, 0, 1'b0, 1'b0, 8'h00);
        do_frame(8'hE9, 32'h0, 0, 0, 1'b0, 1'b0, 8'h00);
        do_frame(8'h03, 32'hAA5A_5A11, 1, 0, 1'b0, 1'b0, 8'h00);
`endif

        for (int f = 0; f < 40; f++) begin
            pick = $urandom_range(0, 7);
            case (pick)
                0: c = 8'h03;
                1: c = 8'h0B;
                2: c = 8'h02;
                3: c = 8'h9F;
                4: c = 8'h05;
                5: c = 8'hB7;
                6: c = 8'hE9;
                default: c = 8'($urandom);
            endcase
            addr = $urandom;
            if (pick == 2 && $urandom_range(0, 1) == 1) addr[7:0] = 8'hFE;
            if ($urandom_range(0, 5) == 0) addr = 32'hFFFF_FFFF;
            status = 8'($urandom);
            do_frame(c, addr, $urandom_range(0, 3),
                     ($urandom_range(0, 4) == 0) ? $urandom_range(1, 60) : 0,
                     $urandom_range(0, 3) == 0, 1'b0, 8'h00);
        end

        // Reset in the middle of a read data phase, ss held low afterwards.
        clear_logs();
        ss_low();
        for (int i = 0; i < 8; i++) begin
            c = 8'h03;
            xbit(c[7-i], 1'b0, r);
        end
        for (int i = 0; i < (mode4 ? 32 : 24); i++) xbit(1'b0, 1'b0, r);
        for (int i = 0; i < 12; i++) xbit(1'($urandom_range(0, 1)), 1'b0, r);
        check_eq("pre_rst_oe", oe_seen, 1);
        rst = 1'b0;
        #1;
        check_eq("async_rst_oe", miso_oe, 0);
        check_eq("async_rst_miso", miso, 0);
        mode4 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        clear_logs();
        for (int i = 0; i < 16; i++) xbit(1'($urandom_range(0, 1)), 1'b0, r);
        check_eq("post_rst_cmd", cmd_log.size(), 0);
        check_eq("post_rst_rd", rd_log.size(), 0);
        check_eq("post_rst_oe", oe_seen, 0);
        ss_high();
        do_frame(8'h9F, 32'h0, 4, 0, 1'b0, 1'b0, 8'h00);

        check_eq("miso_gated", bad_miso, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
